dcache_tag_wr_ctrl: RTL and testbench

//  Write-side controller sitting directly upstream of the dcache tag array (dup copy).

---
 rtl/dcache_tag_wr_ctrl.sv | 109 ++++++++++
 tb/tb_dcache_tag_wr_ctrl.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dcache_tag_wr_ctrl.sv
// Write-side controller for the dcache tag array: reset/flush sweeps that clear every set,
// plus arbitration of refill writes and single-way invalidates onto one registered writeport.
`ifndef DCACHE_WAY_NUM
`define DCACHE_WAY_NUM 4
`endif

module dcache_tag_wr_ctrl #(
  parameter int DATA_WIDTH = 38,
  parameter int ADDR_WIDTH = 9,
  parameter int WAY_NUM    = `DCACHE_WAY_NUM
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  refill_valid,
  output logic                  refill_ready,
  input  logic [ADDR_WIDTH-1:0] refill_idx,
  input  logic [WAY_NUM-1:0]    refill_way,
  input  logic [DATA_WIDTH-1:0] refill_data,
  input  logic                  inval_valid,
  output logic                  inval_ready,
  input  logic [ADDR_WIDTH-1:0] inval_idx,
  input  logic [WAY_NUM-1:0]    inval_way,
  input  logic                  flush_valid,
  output logic                  flush_ready,
  output logic                  flush_done,
  output logic                  init_done,
  input  logic                  req_rd_en,
  input  logic [ADDR_WIDTH-1:0] req_rd_idx,
  output logic                  req_rd_ready,
  output logic                  readport_rd_en,
  output logic [ADDR_WIDTH-1:0] readport_rd_idx,
  output logic                  writeport_wr_en,
  output logic [WAY_NUM-1:0]    writeport_wr_way,
  output logic [ADDR_WIDTH-1:0] writeport_wr_idx,
  output logic [DATA_WIDTH-1:0] writeport_wr_data
);

  localparam logic [ADDR_WIDTH-1:0] LAST_IDX = '1;

  typedef enum logic [1:0] {INIT, IDLE, FLUSH} state_t;

  state_t                state;
  logic [ADDR_WIDTH-1:0] cnt;
  logic                  idle;
  logic                  wr_hit;

  // Lookups to the set currently being written stall for that one cycle; there is no bypass.
  always_comb begin
    idle            = (state == IDLE);
    wr_hit          = writeport_wr_en && (writeport_wr_idx == req_rd_idx);
    flush_ready     = idle;
    refill_ready    = idle && !flush_valid;
    inval_ready     = idle && !flush_valid && !refill_valid;
    req_rd_ready    = idle && !wr_hit;
    readport_rd_en  = req_rd_en && req_rd_ready;
    readport_rd_idx = req_rd_idx;
    init_done       = (state != INIT);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state             <= INIT;
      cnt               <= '0;
      flush_done        <= 1'b0;
      writeport_wr_en   <= 1'b0;
      writeport_wr_way  <= '0;
      writeport_wr_idx  <= '0;
      writeport_wr_data <= '0;
    end else begin
      flush_done <= 1'b0;
      unique case (state)
        INIT, FLUSH: begin
          writeport_wr_en   <= 1'b1;
          writeport_wr_way  <= '1;
          writeport_wr_idx  <= cnt;
          writeport_wr_data <= '0;
          if (cnt == LAST_IDX) begin
            cnt        <= '0;
            state      <= IDLE;
            flush_done <= (state == FLUSH);
          end else begin
            cnt <= cnt + ADDR_WIDTH'(1);
          end
        end
        IDLE: begin
          if (flush_valid) begin
            // The flush cycle itself writes nothing; the sweep starts once in FLUSH.
            state           <= FLUSH;
            writeport_wr_en <= 1'b0;
          end else if (refill_valid) begin
            writeport_wr_en   <= 1'b1;
            writeport_wr_way  <= refill_way;
            writeport_wr_idx  <= refill_idx;
            writeport_wr_data <= refill_data;
          end else if (inval_valid) begin
            writeport_wr_en   <= 1'b1;
            writeport_wr_way  <= inval_way;
            writeport_wr_idx  <= inval_idx;
            writeport_wr_data <= '0;
          end else begin
            writeport_wr_en <= 1'b0;
          end
        end
        default: state <= INIT;
      endcase
    end
  end

endmodule

// File: tb/tb_dcache_tag_wr_ctrl.sv
// Bench for dcache_tag_wr_ctrl: queue-based model of upcoming writes, checked every cycle,
// plus directed scenarios with literal expectations and a randomized traffic phase.
module tb_dcache_tag_wr_ctrl;

  logic        clock = 1'b0;
  logic        reset;
  logic        refill_valid, refill_ready;
  logic [8:0]  refill_idx;
  logic [3:0]  refill_way;
  logic [37:0] refill_data;
  logic        inval_valid, inval_ready;
  logic [8:0]  inval_idx;
  logic [3:0]  inval_way;
  logic        flush_valid, flush_ready, flush_done, init_done;
  logic        req_rd_en, req_rd_ready;
  logic [8:0]  req_rd_idx;
  logic        readport_rd_en;
  logic [8:0]  readport_rd_idx;
  logic        writeport_wr_en;
  logic [3:0]  writeport_wr_way;
  logic [8:0]  writeport_wr_idx;
  logic [37:0] writeport_wr_data;

  dcache_tag_wr_ctrl #(.DATA_WIDTH(38), .ADDR_WIDTH(9), .WAY_NUM(4)) dut (
    .clock(clock), .reset(reset),
    .refill_valid(refill_valid), .refill_ready(refill_ready), .refill_idx(refill_idx),
    .refill_way(refill_way), .refill_data(refill_data),
    .inval_valid(inval_valid), .inval_ready(inval_ready), .inval_idx(inval_idx),
    .inval_way(inval_way),
    .flush_valid(flush_valid), .flush_ready(flush_ready), .flush_done(flush_done),
    .init_done(init_done),
    .req_rd_en(req_rd_en), .req_rd_idx(req_rd_idx), .req_rd_ready(req_rd_ready),
    .readport_rd_en(readport_rd_en), .readport_rd_idx(readport_rd_idx),
    .writeport_wr_en(writeport_wr_en), .writeport_wr_way(writeport_wr_way),
    .writeport_wr_idx(writeport_wr_idx), .writeport_wr_data(writeport_wr_data)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic        en;
    logic [3:0]  way;
    logic [8:0]  idx;
    logic [37:0] data;
  } wr_t;

  wr_t sched[$];     // writes already committed to appear, one per cycle, in order
  wr_t cur;          // what the writeport must show this cycle
  bit  initializing;
  bit  flush_active;
  bit  exp_fd;
  int  tests = 0;
  int  fails = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_sweep();
    for (int i = 0; i < 512; i++) sched.push_back('{1'b1, 4'hF, 9'(i), 38'd0});
  endtask

  task automatic model_reset();
    sched.delete();
    push_sweep();
    cur          = '0;
    initializing = 1'b1;
    flush_active = 1'b0;
    exp_fd       = 1'b0;
  endtask

  task automatic model_advance();
    exp_fd = 1'b0;
    if (reset) begin
      model_reset();
    end else if (sched.size() != 0) begin
      cur = sched.pop_front();
      if (sched.size() == 0) begin
        exp_fd       = flush_active;
        flush_active = 1'b0;
        initializing = 1'b0;
      end
    end else if (flush_valid) begin
      cur = '0;
      push_sweep();
      flush_active = 1'b1;
    end else if (refill_valid) begin
      cur = '{1'b1, refill_way, refill_idx, refill_data};
    end else if (inval_valid) begin
      cur = '{1'b1, inval_way, inval_idx, 38'd0};
    end else begin
      cur.en = 1'b0;
    end
  endtask

  task automatic compare_model();
    bit idle, rd_r;
    idle = (sched.size() == 0);
    rd_r = idle && !(cur.en && cur.idx == req_rd_idx);
    chk("init_done", 64'(init_done), 64'(!initializing));
    chk("flush_done", 64'(flush_done), 64'(exp_fd));
    chk("wr_en", 64'(writeport_wr_en), 64'(cur.en));
    if (cur.en) begin
      chk("wr_way", 64'(writeport_wr_way), 64'(cur.way));
      chk("wr_idx", 64'(writeport_wr_idx), 64'(cur.idx));
      chk("wr_data", 64'(writeport_wr_data), 64'(cur.data));
    end
    chk("flush_ready", 64'(flush_ready), 64'(idle));
    chk("refill_ready", 64'(refill_ready), 64'(idle && !flush_valid));
    chk("inval_ready", 64'(inval_ready), 64'(idle && !flush_valid && !refill_valid));
    chk("req_rd_ready", 64'(req_rd_ready), 64'(rd_r));
    chk("readport_rd_en", 64'(readport_rd_en), 64'(req_rd_en && rd_r));
    chk("readport_rd_idx", 64'(readport_rd_idx), 64'(req_rd_idx));
  endtask

  task automatic settle();
    #1;
    compare_model();
  endtask

  task automatic advance();
    @(posedge clock);
    model_advance();
    @(negedge clock);
  endtask

  task automatic clr();
    refill_valid = 1'b0; refill_idx = '0; refill_way = '0; refill_data = '0;
    inval_valid  = 1'b0; inval_idx  = '0; inval_way  = '0;
    flush_valid  = 1'b0; req_rd_en  = 1'b0; req_rd_idx = '0;
  endtask

  task automatic rnd(input bit allow_flush);
    refill_valid = ($urandom_range(0, 9) < 4);
    refill_idx   = 9'($urandom_range(0, 15));
    refill_way   = 4'($urandom);
    refill_data  = {6'($urandom), 32'($urandom)};
    inval_valid  = ($urandom_range(0, 9) < 4);
    inval_idx    = 9'($urandom_range(0, 15));
    inval_way    = 4'($urandom);
    flush_valid  = allow_flush && ($urandom_range(0, 99) == 0);
    req_rd_en    = ($urandom_range(0, 9) < 6);
    req_rd_idx   = 9'($urandom_range(0, 15));
  endtask

  initial begin
    int  pulses, writes;
    bit  found;
    reset = 1'b1;
    clr();
    model_reset();
    @(negedge clock);
    for (int i = 0; i < 3; i++) begin settle(); advance(); end
    reset = 1'b0;

    // Reset sweep under random requests; nothing may be accepted.
    for (int i = 0; i < 511; i++) begin rnd(1'b0); settle(); advance(); end
    clr();
    settle();
    chk("init_not_yet_done", 64'(init_done), 64'h0);
    chk("init_idx510", 64'(writeport_wr_idx), 64'd510);
    advance();
    settle();
    chk("init_done_with_511", 64'(init_done), 64'h1);
    chk("init_last_en", 64'(writeport_wr_en), 64'h1);
    chk("init_last_idx", 64'(writeport_wr_idx), 64'd511);
    chk("init_last_way", 64'(writeport_wr_way), 64'hF);
    advance();

    // Single refill.
    refill_valid = 1'b1; refill_idx = 9'd5; refill_way = 4'b0010; refill_data = 38'h2_0000_ABCD;
    settle();
    chk("refill5_ready", 64'(refill_ready), 64'h1);
    advance();
    clr();
    settle();
    chk("refill5_en", 64'(writeport_wr_en), 64'h1);
    chk("refill5_idx", 64'(writeport_wr_idx), 64'd5);
    chk("refill5_way", 64'(writeport_wr_way), 64'h2);
    chk("refill5_data", 64'(writeport_wr_data), 64'h2_0000_ABCD);
    advance();
    settle();
    chk("refill5_after_en", 64'(writeport_wr_en), 64'h0);
    advance();

    // Refill beats invalidate in the same cycle.
    refill_valid = 1'b1; refill_idx = 9'd3; refill_way = 4'b0100; refill_data = 38'h12_3456;
    inval_valid  = 1'b1; inval_idx  = 9'd7; inval_way  = 4'b1000;
    settle();
    chk("arb_refill_ready", 64'(refill_ready), 64'h1);
    chk("arb_inval_ready", 64'(inval_ready), 64'h0);
    advance();
    refill_valid = 1'b0;
    settle();
    chk("arb_refill_idx", 64'(writeport_wr_idx), 64'd3);
    chk("arb_inval_ready2", 64'(inval_ready), 64'h1);
    advance();
    clr();
    settle();
    chk("arb_inval_en", 64'(writeport_wr_en), 64'h1);
    chk("arb_inval_idx", 64'(writeport_wr_idx), 64'd7);
    chk("arb_inval_data", 64'(writeport_wr_data), 64'h0);
    chk("arb_inval_way", 64'(writeport_wr_way), 64'h8);
    advance();

    // Read hazard against the write in flight.
    refill_valid = 1'b1; refill_idx = 9'd9; refill_way = 4'b0001; refill_data = 38'h99;
    settle();
    advance();
    clr();
    req_rd_en = 1'b1; req_rd_idx = 9'd9;
    settle();
    chk("haz_same_ready", 64'(req_rd_ready), 64'h0);
    chk("haz_same_rd_en", 64'(readport_rd_en), 64'h0);
    req_rd_idx = 9'd10;
    #1;
    chk("haz_other_ready", 64'(req_rd_ready), 64'h1);
    chk("haz_other_rd_en", 64'(readport_rd_en), 64'h1);
    chk("haz_other_rd_idx", 64'(readport_rd_idx), 64'd10);
    advance();
    req_rd_idx = 9'd9;
    settle();
    chk("haz_next_ready", 64'(req_rd_ready), 64'h1);
    advance();
    clr();

    // Flush wins over refill, then a full sweep with one done pulse.
    flush_valid = 1'b1; refill_valid = 1'b1; refill_idx = 9'd20; refill_way = 4'b0001;
    settle();
    chk("flush_ready", 64'(flush_ready), 64'h1);
    chk("flush_refill_ready", 64'(refill_ready), 64'h0);
    advance();
    clr();
    pulses = 0; writes = 0;
    for (int i = 0; i < 515; i++) begin
      settle();
      if (flush_done) pulses++;
      if (writeport_wr_en) writes++;
      advance();
    end
    chk("flush_pulses", 64'(pulses), 64'd1);
    chk("flush_writes", 64'(writes), 64'd512);
    settle();
    chk("post_flush_fready", 64'(flush_ready), 64'h1);
    chk("post_flush_rready", 64'(refill_ready), 64'h1);
    chk("post_flush_iready", 64'(inval_ready), 64'h1);
    advance();

    // Reset in the middle of a flush sweep.
    flush_valid = 1'b1;
    settle();
    advance();
    clr();
    found = 1'b0;
    for (int i = 0; i < 600 && !found; i++) begin
      settle();
      if (writeport_wr_en && writeport_wr_idx == 9'd200) found = 1'b1;
      else advance();
    end
    chk("sweep_reach_idx200", 64'(found), 64'h1);
    reset = 1'b1;
    model_reset();
    #1;
    chk("rst_mid_wr_en", 64'(writeport_wr_en), 64'h0);
    chk("rst_mid_init_done", 64'(init_done), 64'h0);
    chk("rst_mid_flush_done", 64'(flush_done), 64'h0);
    advance();
    settle();
    advance();
    reset = 1'b0;
    pulses = 0;
    for (int i = 0; i < 515; i++) begin
      settle();
      if (i == 1) begin
        chk("restart_en", 64'(writeport_wr_en), 64'h1);
        chk("restart_idx0", 64'(writeport_wr_idx), 64'd0);
      end
      if (flush_done) pulses++;
      advance();
    end
    chk("restart_no_flush_done", 64'(pulses), 64'd0);

    // Random traffic, occasional flushes.
    for (int i = 0; i < 1500; i++) begin rnd(1'b1); settle(); advance(); end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
